// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
//   Registered result/flag stage that sits after the W-bit ripple add/sub
//   datapath. It takes the (W+1)-bit raw result, where the MSB is the carry
//   (add) or the borrow (sub), and derives the C/B, Z, N and V flags. It stores
//   each result and its flags in a small FIFO. Both sides use valid/ready, so
//   the combinational datapath is decoupled from the consumer. It also keeps a
//   saturating count of delivered results.
//
// Parameters
//   W      operand/result width (raw input is W+1 bits)
//   DEPTH  FIFO entries, 2 or 4 (pointers wrap by natural binary overflow)
//   CNT_W  width of the delivered-result counter
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   upstream result valid
//   in_ready   stage can accept (FIFO not full, registered count only)
//   in_op      0 = add (MSB is carry), 1 = sub (MSB is borrow)
//   in_a_msb   A[W-1], for overflow
//   in_b_msb   B[W-1], for overflow
//   in_res     raw datapath output, bit W = carry/borrow
//   out_valid  head entry valid
//   out_ready  consumer accepts head
//   out_res    head result bits [W-1:0]
//   out_cb     carry/borrow of head entry
//   out_z      head result == 0
//   out_n      head result bit W-1
//   out_v      signed overflow of head entry
//   op_count   number of results popped, saturating
// -----------------------------------------------------------------------------
module alu_result_stage #(
  parameter int W     = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic             in_a_msb,
  input  logic             in_b_msb,
  input  logic [W:0]       in_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_res,
  output logic             out_cb,
  output logic             out_z,
  output logic             out_n,
  output logic             out_v,
  output logic [CNT_W-1:0] op_count
);

  // DEPTH is 2 or 4, so a pointer of this width wraps exactly modulo DEPTH.
  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cb;
    logic         z;
    logic         n;
    logic         v;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CNT_W-1:0] r_op_count;

  entry_t w_entry;
  logic   w_push;
  logic   w_pop;
  logic   w_ovf_add;
  logic   w_ovf_sub;

  // Overflow happens when the sign of the result differs from the sign of A.
  // For add, the operands must also have the same sign. For sub, they must
  // have opposite signs.
  assign w_ovf_add = ~(in_a_msb ^ in_b_msb) & (in_a_msb ^ in_res[W-1]);
  assign w_ovf_sub =  (in_a_msb ^ in_b_msb) & (in_a_msb ^ in_res[W-1]);

  always_comb begin
    w_entry     = '0;
    w_entry.res = in_res[W-1:0];
    w_entry.cb  = in_res[W];
    w_entry.z   = (in_res[W-1:0] == '0);
    w_entry.n   = in_res[W-1];
    w_entry.v   = in_op ? w_ovf_sub : w_ovf_add;
  end

  // Both handshakes use only the registered occupancy. No path from out_ready
  // to in_ready exists, so a full FIFO refuses a push even while it is popping.
  assign in_ready  = (r_count != CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_op_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        if (r_op_count != {CNT_W{1'b1}}) begin
          r_op_count <= r_op_count + 1'b1;
        end
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The outputs always show the head slot. When the FIFO is empty, this is
  // stale storage, which the consumer ignores.
  assign out_res  = r_mem[r_rd_ptr].res;
  assign out_cb   = r_mem[r_rd_ptr].cb;
  assign out_z    = r_mem[r_rd_ptr].z;
  assign out_n    = r_mem[r_rd_ptr].n;
  assign out_v    = r_mem[r_rd_ptr].v;
  assign op_count = r_op_count;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  localparam int W     = 4;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_op;
  logic         in_a_msb;
  logic         in_b_msb;
  logic [W:0]   in_res;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_res;
  logic         out_cb, out_z, out_n, out_v;
  logic [7:0]   op_count;

  // Second instance with a 2-bit counter, driven by the same stimulus.
  logic         in_ready2, out_valid2;
  logic [W-1:0] out_res2;
  logic         out_cb2, out_z2, out_n2, out_v2;
  logic [1:0]   op_count2;

  always #5 clk = ~clk;

  alu_result_stage #(.W(W), .DEPTH(DEPTH), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb), .in_res(in_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_cb(out_cb), .out_z(out_z), .out_n(out_n), .out_v(out_v),
    .op_count(op_count)
  );

  alu_result_stage #(.W(W), .DEPTH(DEPTH), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_op(in_op), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb), .in_res(in_res),
    .out_valid(out_valid2), .out_ready(out_ready), .out_res(out_res2),
    .out_cb(out_cb2), .out_z(out_z2), .out_n(out_n2), .out_v(out_v2),
    .op_count(op_count2)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic         cb;
    logic         z;
    logic         n;
    logic         v;
  } exp_t;

  exp_t q[$];
  exp_t cur_exp;
  int   model_cnt;
  int   model_ops;
  int   model_ops2;
  int   n_tests;
  int   n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Build the raw datapath result and the expected flags from the operands.
  task automatic set_in(input logic [3:0] a, input logic [3:0] b, input logic op);
    logic [4:0] raw;
    int         sr;
    raw = op ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    sr  = op ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
    in_res      = raw;
    in_op       = op;
    in_a_msb    = a[3];
    in_b_msb    = b[3];
    cur_exp.res = raw[3:0];
    cur_exp.cb  = raw[4];
    cur_exp.z   = (raw[3:0] == 4'h0);
    cur_exp.n   = raw[3];
    cur_exp.v   = (sr > 7) || (sr < -8);
  endtask

  // One clock cycle. The task checks the handshakes and head data against the
  // model, then advances one edge and applies the expected push/pop.
  task automatic cycle(output bit accepted);
    bit do_push, do_pop;
    check("in_ready", 32'(in_ready), 32'(model_cnt != DEPTH));
    check("out_valid", 32'(out_valid), 32'(model_cnt != 0));
    check("op_count", 32'(op_count), 32'(model_ops));
    check("op_count_cnt2", 32'(op_count2), 32'(model_ops2));
    if (model_cnt != 0) begin
      check("head", 32'({out_res, out_cb, out_z, out_n, out_v}), 32'(q[0]));
    end
    do_pop  = out_ready && (model_cnt != 0);
    do_push = in_valid && (model_cnt != DEPTH);
    if (do_pop) begin
      $display("[TB] pop  res=%h cb=%b z=%b n=%b v=%b", out_res, out_cb, out_z, out_n, out_v);
    end
    if (do_push) begin
      $display("[TB] push res=%h", in_res);
    end
    @(posedge clk);
    #1;
    if (do_pop) begin
      void'(q.pop_front());
      model_cnt--;
      if (model_ops < 255) model_ops++;
      if (model_ops2 < 3) model_ops2++;
    end
    if (do_push) begin
      q.push_back(cur_exp);
      model_cnt++;
    end
    accepted = do_push;
  endtask

  // Present one operation and hold it until it is accepted (bounded).
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic op);
    bit acc;
    int k;
    set_in(a, b, op);
    in_valid = 1'b1;
    acc = 1'b0;
    k = 0;
    while (!acc && k < 20) begin
      cycle(acc);
      k++;
    end
    check("send_accept_timeout", 32'(acc), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_outs", 32'({out_res, out_cb, out_z, out_n, out_v}), 32'(0));
    check("rst_op_count", 32'(op_count), 32'(0));
    check("rst_op_count2", 32'(op_count2), 32'(0));
    q.delete();
    model_cnt  = 0;
    model_ops  = 0;
    model_ops2 = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'(1));
  endtask

  initial begin
    bit acc;
    n_tests = 0; n_fail = 0;
    model_cnt = 0; model_ops = 0; model_ops2 = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 1'b0; in_a_msb = 1'b0; in_b_msb = 1'b0; in_res = '0;
    cur_exp = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Flag cases (sub 5-3, sub 3-5, sub 8-1, sub 5-5, add 7+1).
    send(4'd5, 4'd3, 1'b1);
    idle(1);
    send(4'd3, 4'd5, 1'b1);
    idle(1);
    send(4'd8, 4'd1, 1'b1);
    idle(1);
    send(4'd5, 4'd5, 1'b1);
    idle(1);
    send(4'd7, 4'd1, 1'b0);
    idle(2);

    // Back-pressure: fill, stall a third, then drain in order.
    out_ready = 1'b0;
    send(4'd1, 4'd2, 1'b0);
    send(4'd9, 4'd9, 1'b0);
    set_in(4'd6, 4'd2, 1'b1);
    in_valid = 1'b1;
    idle(2);
    out_ready = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) cycle(acc);
    check("third_accept", 32'(acc), 32'(1));
    in_valid = 1'b0;
    idle(3);

    // Simultaneous push and pop with back-to-back traffic.
    for (int i = 0; i < 6; i++) begin
      send(4'(i * 3), 4'(i + 2), 1'(i % 2));
    end
    idle(3);
    check("op_count_total", 32'(op_count), 32'(model_ops));

    // Reset mid-stream with two entries buffered.
    out_ready = 1'b0;
    send(4'd2, 4'd3, 1'b0);
    send(4'd4, 4'd4, 1'b0);
    do_reset();
    out_ready = 1'b1;
    idle(3);
    send(4'd15, 4'd15, 1'b0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
